// File: rtl/branch_cond_queue_pkg.sv
// branch_cond_queue_pkg: shared widths, body field offsets and entry layout for the branch condition queue
package branch_cond_queue_pkg;
  localparam int ADDR_W = 64;
  localparam int MAJ_W = 64;
  localparam int MIN_W = 7;
  localparam int PID_W = 20;
  localparam int TID_W = 16;
  localparam int REG_W = 5;
  localparam int IMM_W = 14;
  localparam int BODY_W = 26;
  localparam int BO_OFF = 0;
  localparam int BI_OFF = 5;
  localparam int BD_OFF = 10;
  localparam int AA_OFF = 24;
  localparam int LK_OFF = 25;
  localparam int BRANCH_UNIT_ID = 6;
  typedef struct packed {
    logic [REG_W-1:0] bo;
    logic [REG_W-1:0] bi;
    logic lk;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] link;
    logic [MAJ_W-1:0] maj;
    logic [MIN_W-1:0] min;
    logic [PID_W-1:0] pid;
    logic [TID_W-1:0] tid;
    logic is64;
  } entry_t;
endpackage

// File: rtl/branch_cond_queue_target_calc.sv
// branch_target_calc: combinational branch target and link address for B-form ops
module branch_target_calc
  import branch_cond_queue_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [IMM_W-1:0]  bd_i,
  input  logic              aa_i,
  input  logic              is64_i,
  output logic [ADDR_W-1:0] target_o,
  output logic [ADDR_W-1:0] link_o
);
  logic [ADDR_W-1:0] offset, mask;
  // Word-aligned signed displacement; 32-bit mode clears the upper word of both results
  always_comb begin
    offset = {{(ADDR_W-IMM_W-2){bd_i[IMM_W-1]}}, bd_i, 2'b00};
    mask = is64_i ? '1 : {{(ADDR_W-32){1'b0}}, 32'hFFFF_FFFF};
    target_o = (aa_i ? offset : addr_i + offset) & mask;
    link_o = (addr_i + ADDR_W'(4)) & mask;
  end
endmodule

// File: rtl/branch_cond_queue.sv
// branch_cond_queue: in-order queue of enriched B-form branch ops; define BRANCH_QUEUE_BYPASS_EN for same-cycle empty-queue bypass
module branch_cond_queue
  import branch_cond_queue_pkg::*;
#(
  parameter int addressWidth = ADDR_W,
  parameter int instructionCounterWidth = MAJ_W,
  parameter int instMinIdWidth = MIN_W,
  parameter int PidSize = PID_W,
  parameter int TidSize = TID_W,
  parameter int regSize = REG_W,
  parameter int immediateSize = IMM_W,
  parameter int QueueDepth = 4
) (
  input  logic                               clock_i,
  input  logic                               reset_n_i,
  input  logic                               enable_i,
  input  logic [0:BODY_W-1]                  instructionBody_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [instructionCounterWidth-1:0] instMajId_i,
  input  logic [instMinIdWidth-1:0]          instMinId_i,
  input  logic [PidSize-1:0]                 instPid_i,
  input  logic [TidSize-1:0]                 instTid_i,
  input  logic                               flush_i,
  input  logic                               ready_i,
  output logic                               stall_o,
  output logic                               valid_o,
  output logic [regSize-1:0]                 BO_o,
  output logic [regSize-1:0]                 BI_o,
  output logic                               LK_o,
  output logic [addressWidth-1:0]            target_o,
  output logic [addressWidth-1:0]            linkAddr_o,
  output logic [instructionCounterWidth-1:0] majId_o,
  output logic [instMinIdWidth-1:0]          minId_o,
  output logic [PidSize-1:0]                 pid_o,
  output logic [TidSize-1:0]                 tid_o,
  output logic                               is64Bit_o,
  output logic [$clog2(QueueDepth):0]        count_o
);
  localparam int PTR_W = $clog2(QueueDepth);
  localparam int CNT_W = PTR_W + 1;
  entry_t mem_q [QueueDepth];
  entry_t new_e, head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] tgt, lnk;
  logic push, pop, byp;
  branch_target_calc u_calc (
    .addr_i   (instructionAddress_i),
    .bd_i     (instructionBody_i[BD_OFF +: immediateSize]),
    .aa_i     (instructionBody_i[AA_OFF]),
    .is64_i   (is64Bit_i),
    .target_o (tgt),
    .link_o   (lnk)
  );
`ifdef BRANCH_QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && enable_i && ready_i && !flush_i;
`else
  assign byp = 1'b0;
`endif
  // Enqueue entry assembly, handshake decode, pointer/count next state and head selection
  always_comb begin
    new_e = '{bo: instructionBody_i[BO_OFF +: regSize], bi: instructionBody_i[BI_OFF +: regSize],
              lk: instructionBody_i[LK_OFF], target: tgt, link: lnk, maj: instMajId_i,
              min: instMinId_i, pid: instPid_i, tid: instTid_i, is64: is64Bit_i};
    stall_o = count_q == CNT_W'(QueueDepth);
    push = enable_i && !stall_o && !flush_i && !byp;
    pop = (count_q != '0) && ready_i && !flush_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
    count_d = flush_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    head = byp ? new_e : mem_q[rd_ptr_q];
    valid_o = (count_q != '0) || byp;
    count_o = count_q;
    BO_o = head.bo;
    BI_o = head.bi;
    LK_o = head.lk;
    target_o = head.target;
    linkAddr_o = head.link;
    majId_o = head.maj;
    minId_o = head.min;
    pid_o = head.pid;
    tid_o = head.tid;
    is64Bit_o = head.is64;
  end
  // Pointer, occupancy and entry storage with asynchronous clear
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < QueueDepth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      if (push) mem_q[wr_ptr_q] <= new_e;
    end
  end
endmodule
